// File: rtl/sqrt_pkg.sv
// Shared types and constants for the Q4.4 square-root display.
package sqrt_pkg;

  // Q4.4 field widths
  localparam int unsigned IntW  = 4;
  localparam int unsigned FracW = 4;
  localparam int unsigned DataW = IntW + FracW;

  // Display phases
  typedef enum logic [2:0] {
    StIdle,
    StTens,
    StUnits,
    StFrac,
    StGap
  } state_e;

  // Active-high segments, bit0=a .. bit6=g, entry i drives digit i
  localparam logic [9:0][6:0] SegTable = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit to seven-segment decoder with blanking.
module seg7_decode
  import sqrt_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank on request or for any non-decimal digit
  always_comb begin
    seg_o = 7'h00;
    if (!blank_i && (digit_i <= 4'd9)) begin
      seg_o = SegTable[digit_i];
    end
  end

endmodule

// File: rtl/sqrt_display.sv
// Shows a Q4.4 result as tens, units (with dp), one fractional digit, then a blank gap.
module sqrt_display
  import sqrt_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  input  logic [DataW-1:0] res_data,
  output logic             res_ready,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam logic [7:0] LastCnt = 8'(DWELL - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [DataW-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             xfer;
  logic             last;

  logic [IntW-1:0]  int_part;
  logic [FracW-1:0] frac_part;
  logic [7:0]       frac_x10;
  logic [3:0]       tens_dig, units_dig, frac_dig;
  logic [3:0]       dig_sel;
  logic             blank_sel;

  assign xfer = res_valid && ready_q;
  assign last = (cnt_q == LastCnt);

  // Next-state, dwell counter and capture of the incoming result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d = StTens;
          cnt_d   = 8'd0;
          data_d  = res_data;
        end
      end
      StTens, StUnits, StFrac: begin
        if (last) begin
          cnt_d = 8'd0;
          if (state_q == StTens) begin
            state_d = StUnits;
          end else if (state_q == StUnits) begin
            state_d = StFrac;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (xfer) begin
          state_d = StTens;
          cnt_d   = 8'd0;
          data_d  = res_data;
        end else if (last) begin
          state_d = StTens;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Digit split from the value the next state will display, so outputs are ready on entry
  always_comb begin
    int_part  = data_d[DataW-1:FracW];
    frac_part = data_d[FracW-1:0];
    frac_x10  = {4'b0000, frac_part} * 8'd10;
    frac_dig  = 4'(frac_x10 >> 4);
    if (int_part >= 4'd10) begin
      tens_dig  = 4'd1;
      units_dig = int_part - 4'd10;
    end else begin
      tens_dig  = 4'd0;
      units_dig = int_part;
    end
  end

  // Select the digit and strobes belonging to the upcoming state
  always_comb begin
    dig_sel   = 4'd0;
    blank_sel = 1'b1;
    dp_d      = 1'b0;
    ready_d   = 1'b0;
    unique case (state_d)
      StTens: begin
        dig_sel   = tens_dig;
        blank_sel = (tens_dig == 4'd0);
      end
      StUnits: begin
        dig_sel   = units_dig;
        blank_sel = 1'b0;
        dp_d      = 1'b1;
      end
      StFrac: begin
        dig_sel   = frac_dig;
        blank_sel = 1'b0;
      end
      StIdle, StGap: begin
        ready_d = 1'b1;
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit_i (dig_sel),
    .blank_i (blank_sel),
    .seg_o   (seg_d)
  );

  // State, stored value and registered outputs; reset wins over any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      data_q  <= '0;
      ready_q <= 1'b1;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign res_ready = ready_q;
  assign seg       = seg_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_sqrt_display.sv
// Self-checking bench for sqrt_display against a phase-arithmetic reference model.
module tb_sqrt_display;

  localparam int DWELL = 4;

  logic       clk;
  logic       rst;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic [6:0] seg;
  logic       dp;

  int vectors;
  int errors;

  // Reference model: idle flag, held value, cycles since last transfer
  bit         m_idle;
  logic [7:0] m_val;
  int         m_t;
  logic [6:0] tbl [10];
  logic [8:0] exp_v;

  sqrt_display #(.DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {seg, dp, ready} for the current model state
  function automatic logic [8:0] model_out();
    int ip, ph, tens, units, fd;
    if (m_idle) return {7'h00, 1'b0, 1'b1};
    ip    = int'(m_val[7:4]);
    tens  = ip / 10;
    units = ip % 10;
    fd    = (int'(m_val[3:0]) * 10) / 16;
    ph    = (m_t / DWELL) % 4;
    case (ph)
      0:       return {(tens == 0) ? 7'h00 : tbl[tens], 1'b0, 1'b0};
      1:       return {tbl[units], 1'b1, 1'b0};
      2:       return {tbl[fd], 1'b0, 1'b0};
      default: return {7'h00, 1'b0, 1'b1};
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle past the edge
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic [8:0] cur;
    res_valid = v;
    res_data  = d;
    rst       = r;
    cur       = model_out();
    @(posedge clk);
    if (r) begin
      m_idle = 1'b1;
      m_val  = 8'h00;
      m_t    = 0;
    end else if (v && cur[0]) begin
      m_idle = 1'b0;
      m_val  = d;
      m_t    = 0;
    end else if (!m_idle) begin
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b1);
    vectors++;
    if ({seg, dp, res_ready} !== {7'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got seg=%h dp=%b rdy=%b want seg=00 dp=0 rdy=1", seg, dp, res_ready);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      vectors++;
      if ({seg, dp, res_ready} !== {7'h00, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL idle cyc %0d: got seg=%h dp=%b rdy=%b want 00/0/1", i, seg, dp, res_ready);
      end
    end
  endtask

  // Transfer a value and watch two full display rounds against the model
  task automatic test_value(input string name, input logic [7:0] val,
                            input logic [6:0] t_seg, input logic [6:0] u_seg,
                            input logic [6:0] f_seg);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, val, 1'b0);
    for (int i = 0; i < 8 * DWELL; i++) begin
      exp_v = model_out();
      vectors++;
      if ({seg, dp, res_ready} !== exp_v) begin
        errors++;
        $display("FAIL %s cyc %0d: got seg=%h dp=%b rdy=%b want seg=%h dp=%b rdy=%b",
                 name, i, seg, dp, res_ready, exp_v[8:2], exp_v[1], exp_v[0]);
      end
      // Literal per-phase values on the first round
      if (i < 4 * DWELL) begin
        exp_v = (i < DWELL)     ? {t_seg, 1'b0, 1'b0} :
                (i < 2 * DWELL) ? {u_seg, 1'b1, 1'b0} :
                (i < 3 * DWELL) ? {f_seg, 1'b0, 1'b0} : {7'h00, 1'b0, 1'b1};
        vectors++;
        if ({seg, dp, res_ready} !== exp_v) begin
          errors++;
          $display("FAIL %s lit cyc %0d: got seg=%h dp=%b rdy=%b want seg=%h dp=%b rdy=%b",
                   name, i, seg, dp, res_ready, exp_v[8:2], exp_v[1], exp_v[0]);
        end
      end
      step(1'b0, 8'($urandom), 1'b0);
    end
  endtask

  // Hold valid with a new value while the old one is displayed
  task automatic test_back_to_back();
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hB4, 1'b0);
    for (int i = 0; i < 4 * DWELL; i++) begin
      exp_v = model_out();
      vectors++;
      if ({seg, dp, res_ready} !== exp_v) begin
        errors++;
        $display("FAIL b2b cyc %0d: got seg=%h dp=%b rdy=%b want seg=%h dp=%b rdy=%b",
                 i, seg, dp, res_ready, exp_v[8:2], exp_v[1], exp_v[0]);
      end
      vectors++;
      if (res_ready !== (i == 3 * DWELL)) begin
        errors++;
        $display("FAIL b2b ready cyc %0d: got %b want %b", i, res_ready, (i == 3 * DWELL));
      end
      if (i == 3 * DWELL) break;
      step(1'b1, 8'h5A, 1'b0);
    end
    // Transfer in the first gap cycle, new value's blank tens next
    step(1'b1, 8'h5A, 1'b0);
    vectors++;
    if ({seg, dp, res_ready} !== {7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b tens: got seg=%h dp=%b rdy=%b want 00/0/0", seg, dp, res_ready);
    end
    for (int i = 0; i < DWELL; i++) step(1'b1, 8'h5A, 1'b0);
    vectors++;
    if ({seg, dp, res_ready} !== {7'h6D, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b units: got seg=%h dp=%b rdy=%b want 6d/1/0", seg, dp, res_ready);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hB4, 1'b0);
    for (int i = 0; i < DWELL + 1; i++) step(1'b0, 8'h00, 1'b0);
    // Reset coincident with a valid that would otherwise be ignored
    step(1'b1, 8'h77, 1'b1);
    vectors++;
    if ({seg, dp, res_ready} !== {7'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid: got seg=%h dp=%b rdy=%b want 00/0/1", seg, dp, res_ready);
    end
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3 * DWELL; i++) begin
      exp_v = (i < DWELL) ? {7'h00, 1'b0, 1'b0} :
              (i < 2 * DWELL) ? {7'h3F, 1'b1, 1'b0} : {7'h3F, 1'b0, 1'b0};
      vectors++;
      if ({seg, dp, res_ready} !== exp_v) begin
        errors++;
        $display("FAIL zero cyc %0d: got seg=%h dp=%b rdy=%b want seg=%h dp=%b rdy=%b",
                 i, seg, dp, res_ready, exp_v[8:2], exp_v[1], exp_v[0]);
      end
      step(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_random();
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 59) == 0));
      exp_v = model_out();
      vectors++;
      if ({seg, dp, res_ready} !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d: got seg=%h dp=%b rdy=%b want seg=%h dp=%b rdy=%b",
                 i, seg, dp, res_ready, exp_v[8:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vectors   = 0;
    errors    = 0;
    m_idle    = 1'b1;
    m_val     = 8'h00;
    m_t       = 0;
    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = 8'h00;
    test_reset();
    test_value("xfer_b4", 8'hB4, 7'h06, 7'h06, 7'h5B);
    test_value("xfer_5a", 8'h5A, 7'h00, 7'h6D, 7'h7D);
    test_value("xfer_ff", 8'hFF, 7'h06, 7'h6D, 7'h6F);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
